// File: rtl/mac_array.sv
// mac_array: LANES-wide pipelined fixed-point multiply-accumulate engine for one layer,
// with optional ReLU and a saturated sum-of-squares goodness result.
module mac_array #(
  parameter int NUM_NEURONS = 256,
  parameter int INPUT_SIZE  = 784,
  parameter int LANES       = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int FRAC_BITS   = 16,
  parameter int ACC_WIDTH   = 64,
  localparam int GROUPS = NUM_NEURONS / LANES,
  localparam int WW = (GROUPS * INPUT_SIZE > 1) ? $clog2(GROUPS * INPUT_SIZE) : 1,
  localparam int KW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1,
  localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          relu_en,
  output logic                          busy,
  output logic                          done,
  output logic                          w_en,
  output logic [WW-1:0]                 w_addr,
  input  logic [LANES*DATA_WIDTH-1:0]   w_rdata,
  output logic                          act_en,
  output logic [KW-1:0]                 act_addr,
  input  logic [DATA_WIDTH-1:0]         act_rdata,
  output logic                          out_we,
  output logic [GW-1:0]                 out_addr,
  output logic [LANES*DATA_WIDTH-1:0]   out_wdata,
  output logic [DATA_WIDTH-1:0]         goodness
);
  localparam int PW = 2 * DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WRITE} state_t;
  state_t state, state_nxt;
  logic relu;
  logic [GW-1:0] group;
  logic signed [ACC_WIDTH-1:0] acc [LANES];
  logic signed [ACC_WIDTH-1:0] acc_nxt [LANES];
  logic signed [PW-1:0] prod [LANES];
  logic signed [PW-1:0] sq [LANES];
  logic [DATA_WIDTH-1:0] lane_out [LANES];
  logic [LANES*DATA_WIDTH-1:0] wdata_nxt;
  logic signed [ACC_WIDTH-1:0] gacc, gacc_nxt;
  logic last_k, last_g;

  function automatic logic [DATA_WIDTH-1:0] sat(input logic [ACC_WIDTH-1:0] v);
    return (&v[ACC_WIDTH-1:DATA_WIDTH-1] || ~|v[ACC_WIDTH-1:DATA_WIDTH-1]) ? v[DATA_WIDTH-1:0]
         : {v[ACC_WIDTH-1], {(DATA_WIDTH-1){~v[ACC_WIDTH-1]}}};
  endfunction

  assign busy   = state != IDLE;
  assign last_k = act_addr == KW'(INPUT_SIZE - 1);
  assign last_g = group == GW'(GROUPS - 1);

  // lane outputs and goodness are only meaningful in DRAIN, when acc_nxt holds the final sum
  always_comb begin
    gacc_nxt  = gacc;
    wdata_nxt = '0;
    for (int l = 0; l < LANES; l++) begin
      prod[l]     = PW'($signed(w_rdata[l*DATA_WIDTH +: DATA_WIDTH])) * PW'($signed(act_rdata));
      acc_nxt[l]  = acc[l] + ACC_WIDTH'(prod[l] >>> FRAC_BITS);
      lane_out[l] = (relu && acc_nxt[l][ACC_WIDTH-1]) ? '0 : sat(acc_nxt[l]);
      sq[l]       = PW'($signed(lane_out[l])) * PW'($signed(lane_out[l]));
      gacc_nxt    = gacc_nxt + ACC_WIDTH'(sq[l] >>> FRAC_BITS);
      wdata_nxt[l*DATA_WIDTH +: DATA_WIDTH] = lane_out[l];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? FETCH : IDLE;
      FETCH:   state_nxt = last_k ? DRAIN : FETCH;
      DRAIN:   state_nxt = WRITE;
      WRITE:   state_nxt = last_g ? IDLE : FETCH;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      relu      <= 1'b0;
      group     <= '0;
      gacc      <= '0;
      done      <= 1'b0;
      w_en      <= 1'b0;
      act_en    <= 1'b0;
      out_we    <= 1'b0;
      w_addr    <= '0;
      act_addr  <= '0;
      out_addr  <= '0;
      out_wdata <= '0;
      goodness  <= '0;
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
    end else begin
      w_en   <= state_nxt == FETCH;
      act_en <= state_nxt == FETCH;
      out_we <= !abort && state == DRAIN;
      done   <= !abort && state == DRAIN && last_g;
      if (!abort) begin
        case (state)
          IDLE: if (start) begin
            relu     <= relu_en;
            group    <= '0;
            w_addr   <= '0;
            act_addr <= '0;
            gacc     <= '0;
            for (int l = 0; l < LANES; l++) acc[l] <= '0;
          end
          FETCH: begin
            if (act_addr != '0) for (int l = 0; l < LANES; l++) acc[l] <= acc_nxt[l];
            if (!last_k) begin
              act_addr <= act_addr + KW'(1);
              w_addr   <= w_addr + WW'(1);
            end
          end
          DRAIN: begin
            out_addr  <= group;
            out_wdata <= wdata_nxt;
            gacc      <= gacc_nxt;
            if (last_g) goodness <= sat(gacc_nxt);
          end
          WRITE: begin
            for (int l = 0; l < LANES; l++) acc[l] <= '0;
            if (!last_g) begin
              group    <= group + GW'(1);
              act_addr <= '0;
              w_addr   <= w_addr + WW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mac_array.sv
// tb_mac_array: scenario tasks for mac_array against spec constants and a behavioural model.
module tb_mac_array;
  localparam int NN = 8, IS = 4, L = 4, DW = 32, G = NN / L;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk = 0, rst_n = 0, start = 0, abort = 0, relu_en = 0;
  logic busy, done, w_en, act_en, out_we;
  logic [2:0] w_addr;
  logic [1:0] act_addr;
  logic [0:0] out_addr;
  logic [L*DW-1:0] w_rdata = '0, out_wdata;
  logic [DW-1:0] act_rdata = '0, goodness;

  logic [L*DW-1:0] wmem [G*IS];
  logic [DW-1:0] amem [IS];
  logic [L*DW-1:0] exp_word [G];
  logic [DW-1:0] exp_good;
  logic [L*DW-1:0] sv_word [G];
  logic [DW-1:0] sv_good;
  int total = 0, bad = 0, cyc = 0, t0 = 0;
  logic busy_after;
  int we_cyc[$];
  logic [0:0] we_addr[$];
  logic [L*DW-1:0] we_data[$];
  int done_cyc[$];
  int req_w[$];
  int req_a[$];
  int en_q[$];

  mac_array #(.NUM_NEURONS(NN), .INPUT_SIZE(IS), .LANES(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .relu_en(relu_en),
    .busy(busy), .done(done), .w_en(w_en), .w_addr(w_addr), .w_rdata(w_rdata),
    .act_en(act_en), .act_addr(act_addr), .act_rdata(act_rdata),
    .out_we(out_we), .out_addr(out_addr), .out_wdata(out_wdata), .goodness(goodness)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (w_en) w_rdata <= wmem[w_addr];
    if (act_en) act_rdata <= amem[act_addr];
  end

  always @(negedge clk) if (rst_n) begin
    if (out_we) begin
      we_cyc.push_back(cyc - t0 + 1);
      we_addr.push_back(out_addr);
      we_data.push_back(out_wdata);
    end
    if (done) done_cyc.push_back(cyc - t0 + 1);
    if (w_en !== act_en) en_q.push_back(cyc);
    if (w_en) begin
      req_w.push_back(int'(w_addr));
      req_a.push_back(int'(act_addr));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic void model(input bit relu);
    longint g = 0;
    for (int n = 0; n < NN; n++) begin
      longint acc = 0, o;
      int w, a;
      for (int k = 0; k < IS; k++) begin
        w = wmem[(n / L) * IS + k][(n % L) * DW +: DW];
        a = amem[k];
        acc += (longint'(w) * longint'(a)) >>> 16;
      end
      o = acc > MAXV ? MAXV : acc < MINV ? MINV : acc;
      if (relu && o < 0) o = 0;
      exp_word[n / L][(n % L) * DW +: DW] = o[31:0];
      g += (o * o) >>> 16;
    end
    g = g > MAXV ? MAXV : g < MINV ? MINV : g;
    exp_good = g[31:0];
  endfunction

  function automatic logic [31:0] rnd();
    return ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1 << 19)) - 32'h0004_0000;
  endfunction

  task automatic fill(input logic [DW-1:0] wv, input logic [DW-1:0] av);
    for (int i = 0; i < G * IS; i++) wmem[i] = {L{wv}};
    for (int k = 0; k < IS; k++) amem[k] = av;
  endtask

  task automatic clear_logs;
    we_cyc.delete(); we_addr.delete(); we_data.delete(); done_cyc.delete();
    req_w.delete(); req_a.delete(); en_q.delete();
  endtask

  task automatic run_pass(input bit relu, input int poke);
    bit fin = 0;
    clear_logs();
    model(relu);
    @(negedge clk); relu_en = relu; start = 1;
    @(posedge clk); #1 t0 = cyc; start = 0; relu_en = !relu;
    for (int i = 1; i < 200 && !fin; i++) begin
      @(negedge clk);
      fin = done;
      start = (i == poke);
    end
    start = 0;
    total++;
    if (!fin) begin bad++; $display("FAIL pass_timeout: done=%b, required 1 within 200 cycles", done); end
    @(negedge clk); busy_after = busy;
  endtask

  task automatic test_reset;
    #12;
    total++;
    if ({busy, done, w_en, act_en, out_we, w_addr, act_addr, out_addr, out_wdata, goodness} !== '0) begin
      bad++; $display("FAIL reset_outputs: got busy=%b w_en=%b goodness=%h wdata=%h, required all 0", busy, w_en, goodness, out_wdata);
    end
    @(negedge clk); rst_n = 1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, w_en, act_en, out_we, done} !== 5'b0) begin
      bad++; $display("FAIL reset_idle: got busy=%b w_en=%b act_en=%b out_we=%b done=%b, required 0", busy, w_en, act_en, out_we, done);
    end
  endtask

  task automatic test_basic;
    int errs = 0;
    fill(32'h0001_0000, 32'h0000_8000);
    run_pass(0, 0);
    total++;
    if (we_cyc.size() != G) begin bad++; $display("FAIL basic_writes: got %0d, required %0d", we_cyc.size(), G); end
    else for (int g = 0; g < G; g++) begin
      total++;
      if (we_cyc[g] != 6 * (g + 1) || we_addr[g] !== 1'(g) || we_data[g] !== {L{32'h0002_0000}}) begin
        bad++; $display("FAIL basic_write[%0d]: got cyc=%0d addr=%0d data=%h, required cyc=%0d addr=%0d data=%h",
                        g, we_cyc[g], we_addr[g], we_data[g], 6 * (g + 1), g, {L{32'h0002_0000}});
      end
    end
    total++;
    if (!(done_cyc.size() == 1 && done_cyc[0] == 12)) begin
      bad++; $display("FAIL basic_done: got %0d pulses (first at %0d), required one at 12", done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1);
    end
    total++;
    if (goodness !== 32'h0020_0000) begin bad++; $display("FAIL basic_goodness: got %h, required 00200000", goodness); end
    total++;
    if (busy_after !== 1'b0) begin bad++; $display("FAIL basic_busy_after_done: got %b, required 0", busy_after); end
    for (int i = 0; i < req_w.size(); i++) if (req_w[i] != i || req_a[i] != i % IS) errs++;
    total++;
    if (req_w.size() != G * IS || errs != 0 || en_q.size() != 0) begin
      bad++; $display("FAIL basic_requests: got %0d requests, %0d bad addrs, %0d en splits, required %0d, 0, 0", req_w.size(), errs, en_q.size(), G * IS);
    end
    for (int g = 0; g < G; g++) sv_word[g] = we_data.size() > g ? we_data[g] : 'x;
    sv_good = goodness;
  endtask

  task automatic test_negative;
    for (int r = 0; r < 2; r++) begin
      logic [DW-1:0] lane_v = r ? 32'h0 : 32'hFFFC_0000;
      logic [DW-1:0] good_v = r ? 32'h0 : 32'h0080_0000;
      fill(32'hFFFF_0000, 32'h0001_0000);
      run_pass(r[0], 0);
      total++;
      if (we_data.size() != G) begin bad++; $display("FAIL neg_writes relu=%0d: got %0d, required %0d", r, we_data.size(), G); end
      else for (int g = 0; g < G; g++) begin
        total++;
        if (we_data[g] !== {L{lane_v}}) begin bad++; $display("FAIL neg_data relu=%0d g=%0d: got %h, required %h", r, g, we_data[g], {L{lane_v}}); end
      end
      total++;
      if (goodness !== good_v) begin bad++; $display("FAIL neg_goodness relu=%0d: got %h, required %h", r, goodness, good_v); end
    end
  endtask

  task automatic test_saturation;
    for (int r = 0; r < 2; r++) begin
      logic [DW-1:0] lane_v = r ? 32'h8000_0000 : 32'h7FFF_FFFF;
      fill(r ? 32'h8001_0000 : 32'h7FFF_0000, 32'h7FFF_0000);
      run_pass(0, 0);
      total++;
      if (we_data.size() != G) begin bad++; $display("FAIL sat_writes case=%0d: got %0d, required %0d", r, we_data.size(), G); end
      else for (int g = 0; g < G; g++) begin
        total++;
        if (we_data[g] !== {L{lane_v}}) begin bad++; $display("FAIL sat_data case=%0d g=%0d: got %h, required %h", r, g, we_data[g], {L{lane_v}}); end
      end
      total++;
      if (goodness !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sat_goodness case=%0d: got %h, required 7fffffff", r, goodness); end
    end
  endtask

  task automatic test_lane_order;
    for (int i = 0; i < G * IS; i++)
      for (int l = 0; l < L; l++) wmem[i][l*DW +: DW] = 32'(l + 1) << 16;
    for (int k = 0; k < IS; k++) amem[k] = 32'h0001_0000;
    run_pass(0, 0);
    total++;
    if (we_data.size() != G) begin bad++; $display("FAIL lane_writes: got %0d, required %0d", we_data.size(), G); end
    else for (int g = 0; g < G; g++) begin
      total++;
      if (we_data[g] !== {32'h0010_0000, 32'h000C_0000, 32'h0008_0000, 32'h0004_0000}) begin
        bad++; $display("FAIL lane_data g=%0d: got %h, required 00100000000c00000008000000040000", g, we_data[g]);
      end
    end
    total++;
    if (goodness !== 32'h03C0_0000) begin bad++; $display("FAIL lane_goodness: got %h, required 03c00000", goodness); end
  endtask

  task automatic test_start_busy;
    for (int p = 3; p <= 9; p += 6) begin
      fill(32'h0001_0000, 32'h0000_8000);
      run_pass(0, p);
      total++;
      if (we_cyc.size() != G || we_cyc[G-1] != 12 || we_data[0] !== sv_word[0] || we_data[G-1] !== sv_word[G-1] || goodness !== sv_good) begin
        bad++; $display("FAIL start_busy poke=%0d: got %0d writes, last at %0d, goodness %h, required %0d writes, last at 12, goodness %h",
                        p, we_cyc.size(), we_cyc.size() ? we_cyc[we_cyc.size()-1] : -1, goodness, G, sv_good);
      end
    end
  endtask

  task automatic test_abort(input int at);
    logic [DW-1:0] g_prev;
    g_prev = goodness;
    fill(32'hFFFF_0000, 32'h0001_0000);
    clear_logs();
    @(negedge clk); relu_en = 0; start = 1;
    @(posedge clk); #1 t0 = cyc; start = 0;
    repeat (at) @(negedge clk);
    abort = 1;
    @(posedge clk); #1 abort = 0;
    total++;
    if ({busy, w_en, act_en, out_we, done} !== 5'b0) begin
      bad++; $display("FAIL abort_next at=%0d: got busy=%b w_en=%b act_en=%b out_we=%b done=%b, required 0", at, busy, w_en, act_en, out_we, done);
    end
    repeat (20) @(negedge clk);
    total++;
    if (done_cyc.size() != 0 || we_cyc.size() != 1 || busy !== 1'b0) begin
      bad++; $display("FAIL abort_quiet at=%0d: got %0d done, %0d writes, busy=%b, required 0, 1, 0", at, done_cyc.size(), we_cyc.size(), busy);
    end
    total++;
    if (goodness !== g_prev) begin bad++; $display("FAIL abort_goodness at=%0d: got %h, required %h", at, goodness, g_prev); end
    fill(32'h0001_0000, 32'h0000_8000);
    run_pass(0, 0);
    total++;
    if (we_data.size() != G || we_data[0] !== sv_word[0] || we_data[G-1] !== sv_word[G-1] || goodness !== sv_good ||
        done_cyc.size() != 1 || done_cyc[0] != 12) begin
      bad++; $display("FAIL abort_restart at=%0d: got %0d writes, goodness %h, required %0d writes, goodness %h, done at 12", at, we_data.size(), goodness, G, sv_good);
    end
  endtask

  task automatic test_async_reset;
    fill(32'h0001_0000, 32'h0000_8000);
    @(negedge clk); relu_en = 0; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1;
    total++;
    if ({busy, done, w_en, act_en, out_we, w_addr, act_addr, out_addr, out_wdata, goodness} !== '0) begin
      bad++; $display("FAIL async_reset: got busy=%b w_en=%b act_en=%b w_addr=%0d act_addr=%0d goodness=%h, required all 0",
                      busy, w_en, act_en, w_addr, act_addr, goodness);
    end
    @(negedge clk); rst_n = 1;
    repeat (4) @(negedge clk);
    total++;
    if ({busy, w_en, act_en, out_we, done} !== 5'b0) begin
      bad++; $display("FAIL async_reset_idle: got busy=%b w_en=%b out_we=%b, required 0", busy, w_en, out_we);
    end
    run_pass(0, 0);
    total++;
    if (goodness !== sv_good || we_data.size() != G || we_data[0] !== sv_word[0]) begin
      bad++; $display("FAIL async_reset_rerun: got goodness %h, %0d writes, required %h, %0d", goodness, we_data.size(), sv_good, G);
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 8; it++) begin
      bit relu = 1'($urandom_range(0, 1));
      for (int i = 0; i < G * IS; i++)
        for (int l = 0; l < L; l++) wmem[i][l*DW +: DW] = rnd();
      for (int k = 0; k < IS; k++) amem[k] = rnd();
      run_pass(relu, 0);
      total++;
      if (we_data.size() != G) begin bad++; $display("FAIL rand_writes it=%0d: got %0d, required %0d", it, we_data.size(), G); end
      else for (int g = 0; g < G; g++) begin
        total++;
        if (we_data[g] !== exp_word[g]) begin bad++; $display("FAIL rand_data it=%0d relu=%0d g=%0d: got %h, required %h", it, relu, g, we_data[g], exp_word[g]); end
      end
      total++;
      if (goodness !== exp_good) begin bad++; $display("FAIL rand_goodness it=%0d relu=%0d: got %h, required %h", it, relu, goodness, exp_good); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_lane_order();
    test_start_busy();
    test_abort(8);
    test_abort(11);
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
